// File: rtl/uart_dbg_bridge.sv
// UART byte-stream debug master: decodes W/R/? frames from the receive side,
// runs one 32-bit bus cycle per W/R frame and streams the response bytes back.
module uart_dbg_bridge #(
    parameter int unsigned BUS_TIMEOUT = 1024,
    parameter int unsigned RX_TIMEOUT  = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] CMD_PING = 8'h3F;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;
    localparam logic [7:0] RSP_PING = 8'hA5;

    localparam logic [31:0] BUS_TO_C = 32'(BUS_TIMEOUT);
    localparam logic [31:0] RX_TO_C  = 32'(RX_TIMEOUT);

    function automatic logic is_bus_cmd(input logic [7:0] b);
        return (b == CMD_WR) || (b == CMD_RD);
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [1:0]  byte_cnt_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        bus_req_r;
    logic [3:0]  bus_sel_r;
    logic [31:0] bus_cnt_r;
    logic [31:0] rx_cnt_r;
    logic [31:0] resp_r;
    logic [2:0]  resp_left_r;
    logic        tx_valid_r;
    logic [7:0]  tx_data_r;

    logic        rx_ready_s;
    logic        rx_fire_s;
    logic        tx_fire_s;
    logic        last_byte_s;
    logic [31:0] bus_cnt_inc_s;
    logic [31:0] rx_cnt_inc_s;
    logic        bus_to_s;
    logic        rx_to_s;
    logic        resp_load_s;
    logic [31:0] resp_val_s;
    logic [2:0]  resp_len_s;

    // Handshake qualifiers and timeout detection
    always_comb begin
        rx_ready_s    = (state_r == ST_IDLE) || (state_r == ST_ADDR) || (state_r == ST_DATA);
        rx_fire_s     = rx_valid && rx_ready_s;
        tx_fire_s     = tx_valid_r && tx_ready;
        last_byte_s   = (byte_cnt_r == 2'd3);
        bus_cnt_inc_s = bus_cnt_r + 32'd1;
        rx_cnt_inc_s  = rx_cnt_r + 32'd1;
        // An ack in the final allowed cycle takes precedence over the timeout
        bus_to_s      = (state_r == ST_BUS) && !bus_ack && (bus_cnt_inc_s == BUS_TO_C);
        rx_to_s       = ((state_r == ST_ADDR) || (state_r == ST_DATA)) && !rx_fire_s
                        && (rx_cnt_inc_s == RX_TO_C);
    end

    // Frame/bus/response sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_fire_s) begin
                    if (is_bus_cmd(rx_data)) begin
                        state_nxt_s = ST_ADDR;
                    end else begin
                        state_nxt_s = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (rx_fire_s && last_byte_s) begin
                    state_nxt_s = we_r ? ST_DATA : ST_BUS;
                end else if (rx_to_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (rx_fire_s && last_byte_s) begin
                    state_nxt_s = ST_BUS;
                end else if (rx_to_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_BUS: begin
                if (bus_ack || bus_to_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_BUS;
                end
            end
            ST_RESP: begin
                if (tx_fire_s && (resp_left_r == 3'd0)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Response payload chosen on entry to RESP (bytes go out LSB first)
    always_comb begin
        resp_load_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
        resp_val_s  = 32'h0000_0000;
        resp_len_s  = 3'd0;
        case (state_r)
            ST_IDLE: begin
                resp_len_s = 3'd1;
                if (rx_data == CMD_PING) begin
                    resp_val_s = {24'h00_0000, RSP_PING};
                end else begin
                    resp_val_s = {24'h00_0000, RSP_NAK};
                end
            end
            ST_BUS: begin
                if (bus_ack && !we_r) begin
                    resp_val_s = bus_rdata;
                    resp_len_s = 3'd4;
                end else if (bus_ack) begin
                    resp_val_s = {24'h00_0000, RSP_ACK};
                    resp_len_s = 3'd1;
                end else begin
                    resp_val_s = {24'h00_0000, RSP_NAK};
                    resp_len_s = 3'd1;
                end
            end
            default: begin
                resp_val_s = 32'h0000_0000;
                resp_len_s = 3'd0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame field capture: little-endian shift-in of address and write data
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_r <= 2'd0;
            we_r       <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
        end else if (rx_fire_s) begin
            case (state_r)
                ST_IDLE: begin
                    byte_cnt_r <= 2'd0;
                    if (is_bus_cmd(rx_data)) begin
                        we_r <= (rx_data == CMD_WR);
                    end
                end
                ST_ADDR: begin
                    addr_r     <= {rx_data, addr_r[31:8]};
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                end
                ST_DATA: begin
                    wdata_r    <= {rx_data, wdata_r[31:8]};
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                end
                default: begin
                    byte_cnt_r <= byte_cnt_r;
                end
            endcase
        end
    end

    // Bus request and byte enables follow the BUS state one cycle ahead
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_r <= 1'b0;
            bus_sel_r <= 4'h0;
        end else begin
            bus_req_r <= (state_nxt_s == ST_BUS);
            bus_sel_r <= (state_nxt_s == ST_BUS) ? 4'hF : 4'h0;
        end
    end

    // Bus-cycle and inter-byte idle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_cnt_r <= 32'd0;
            rx_cnt_r  <= 32'd0;
        end else begin
            bus_cnt_r <= ((state_r == ST_BUS) && (state_nxt_s == ST_BUS)) ? bus_cnt_inc_s : 32'd0;
            rx_cnt_r  <= (((state_r == ST_ADDR) || (state_r == ST_DATA)) && !rx_fire_s && !rx_to_s)
                         ? rx_cnt_inc_s : 32'd0;
        end
    end

    // Response serializer: next byte replaces the accepted one with no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_r      <= 32'h0000_0000;
            resp_left_r <= 3'd0;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
        end else if (resp_load_s) begin
            resp_r      <= resp_val_s;
            resp_left_r <= resp_len_s;
        end else if (state_r == ST_RESP) begin
            if (tx_fire_s && (resp_left_r == 3'd0)) begin
                tx_valid_r <= 1'b0;
            end else if (!tx_valid_r || tx_fire_s) begin
                tx_valid_r  <= 1'b1;
                tx_data_r   <= resp_r[7:0];
                resp_r      <= {8'h00, resp_r[31:8]};
                resp_left_r <= resp_left_r - 3'd1;
            end
        end
    end

    assign rx_ready  = rx_ready_s;
    assign tx_valid  = tx_valid_r;
    assign tx_data   = tx_data_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = we_r;
    assign bus_addr  = addr_r & 32'hFFFF_FFFC;
    assign bus_wdata = wdata_r;
    assign bus_sel   = bus_sel_r;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Bench for uart_dbg_bridge: directed vector table, hand-written corner
// sequences and random frames scored against a frame-level reference model.
module tb_uart_dbg_bridge;

    localparam int BUS_TO = 16;
    localparam int RX_TO  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    uart_dbg_bridge #(.BUS_TIMEOUT(BUS_TO), .RX_TIMEOUT(RX_TO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Environment configuration and observations for the current frame
    int          ack_at_cfg = 0;
    logic [31:0] rdata_cfg = 32'h0;
    bit          tx_rand = 1'b0;
    logic [7:0]  got[$];
    int          ops_seen = 0;
    int          stab_err = 0;
    logic [31:0] op_addr, op_wdata;
    logic        op_we;
    logic [3:0]  op_sel;
    int          req_cnt = 0;
    int          req_cycles = -1;
    int          req_fall_cyc = -1;
    int          txv_rise_cyc = -1;
    int          last_acc = 0;
    bit          req_prev = 1'b0;
    bit          txv_prev = 1'b0;

    typedef struct {
        logic [71:0] fr;
        int          n;
        int          ack_at;
        logic [31:0] rdata;
        bit          txr;
        bit          e_bus;
        logic [31:0] e_addr;
        bit          e_we;
        logic [31:0] e_wdata;
        int          e_req;
        int          e_n;
        logic [31:0] e_resp;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(logic [71:0] fr, int n, int ack_at, logic [31:0] rd, bit txr,
                                bit eb, logic [31:0] ea, bit ewe, logic [31:0] ewd,
                                int ereq, int en, logic [31:0] eresp);
        vec_t v;
        v.fr = fr; v.n = n; v.ack_at = ack_at; v.rdata = rd; v.txr = txr;
        v.e_bus = eb; v.e_addr = ea; v.e_we = ewe; v.e_wdata = ewd;
        v.e_req = ereq; v.e_n = en; v.e_resp = eresp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave: acks in the ack_at-th cycle of a request, records the op
    initial begin
        forever begin
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (rst) begin
                req_cnt = 0;
            end else if (bus_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    ops_seen++;
                    op_addr = bus_addr; op_we = bus_we; op_wdata = bus_wdata; op_sel = bus_sel;
                end else if ({bus_addr, bus_we, bus_wdata, bus_sel} !== {op_addr, op_we, op_wdata, op_sel}) begin
                    stab_err++;
                end
                if (req_cnt == ack_at_cfg) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata_cfg;
                end
            end else begin
                if (req_prev) begin
                    req_cycles   = req_cnt;
                    req_fall_cyc = cyc;
                end
                req_cnt = 0;
            end
            req_prev = bus_req;
            if (tx_valid && !txv_prev && txv_rise_cyc < 0) txv_rise_cyc = cyc;
            txv_prev = tx_valid;
        end
    end

    // Transmit sink with optional random backpressure
    initial begin
        forever begin
            @(negedge clk);
            tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready && !rst) got.push_back(tx_data);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("rx_accept_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        last_acc = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic begin_frame(input int ack_at, input logic [31:0] rd, input bit txr);
        ack_at_cfg = ack_at; rdata_cfg = rd; tx_rand = txr;
        got.delete();
        ops_seen = 0; stab_err = 0;
        req_cycles = -1; req_fall_cyc = -1; txv_rise_cyc = -1;
    endtask

    task automatic finish_frame(input bit e_bus, input logic [31:0] e_addr, input bit e_we,
                                input logic [31:0] e_wdata, input int e_req, input int e_n,
                                input logic [31:0] e_resp, input bit chk_lat);
        int n;
        chk("req_after_last", 32'(bus_req), 32'(e_bus));
        n = 0;
        while (!(got.size() >= e_n && !bus_req && !tx_valid && rx_ready) && n < BUS_TO + 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUS_TO + 200) chk("frame_done_wait", 32'(n), 32'd0);
        repeat (4) @(negedge clk);
        chk("bus_ops", 32'(ops_seen), 32'(e_bus));
        if (e_bus) begin
            chk("bus_addr", op_addr, e_addr);
            chk("bus_we", 32'(op_we), 32'(e_we));
            chk("bus_sel", 32'(op_sel), 32'hF);
            chk("bus_stable", 32'(stab_err), 32'd0);
            chk("req_cycles", 32'(req_cycles), 32'(e_req));
            if (e_we) chk("bus_wdata", op_wdata, e_wdata);
            if (chk_lat) chk("tx_lat_bus", 32'(txv_rise_cyc - req_fall_cyc), 32'd1);
        end else if (chk_lat) begin
            chk("tx_lat", 32'(txv_rise_cyc - last_acc), 32'd1);
        end
        chk("resp_len", 32'(got.size()), 32'(e_n));
        for (int i = 0; i < e_n && i < got.size(); i++) begin
            chk("resp_byte", 32'(got[i]), 32'(e_resp[8*i +: 8]));
        end
        chk("rx_ready_idle", 32'(rx_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        begin_frame(v.ack_at, v.rdata, v.txr);
        for (int i = 0; i < v.n; i++) send_byte(v.fr[8*i +: 8]);
        finish_frame(v.e_bus, v.e_addr, v.e_we, v.e_wdata, v.e_req, v.e_n, v.e_resp, 1'b1);
    endtask

    // Frame-level reference: what the host should see for a given frame and bus behaviour
    task automatic model(input logic [71:0] fr, input int ack_at, input logic [31:0] rd,
                         output bit e_bus, output logic [31:0] e_addr, output bit e_we,
                         output logic [31:0] e_wdata, output int e_req, output int e_n,
                         output logic [31:0] e_resp);
        logic [7:0] cmd;
        bit acked;
        cmd     = fr[7:0];
        acked   = (ack_at >= 1) && (ack_at <= BUS_TO);
        e_bus   = (cmd == 8'h57) || (cmd == 8'h52);
        e_we    = (cmd == 8'h57);
        e_addr  = fr[39:8] & 32'hFFFF_FFFC;
        e_wdata = fr[71:40];
        e_req   = acked ? ack_at : BUS_TO;
        e_n     = 1;
        if (cmd == 8'h57)      e_resp = acked ? 32'h06 : 32'h15;
        else if (cmd == 8'h3F) e_resp = 32'hA5;
        else if (cmd == 8'h52 && acked) begin e_resp = rd; e_n = 4; end
        else                   e_resp = 32'h15;
    endtask

    initial begin
        vecs[0] = mk(72'h3F, 1, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1, 32'hA5);
        vecs[1] = mk(72'hDE_AD_BE_EF_80_00_00_10_57, 9, 3, 32'h0, 1'b0,
                     1'b1, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 3, 1, 32'h06);
        vecs[2] = mk(72'h00_00_00_04_52, 5, 2, 32'h1234_5678, 1'b1,
                     1'b1, 32'h4, 1'b0, 32'h0, 2, 4, 32'h1234_5678);
        vecs[3] = mk(72'h01_00_52, 5, 0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, BUS_TO, 1, 32'h15);
        vecs[4] = mk(72'h02_00_52, 5, BUS_TO, 32'hCAFE_F00D, 1'b1,
                     1'b1, 32'h200, 1'b0, 32'h0, BUS_TO, 4, 32'hCAFE_F00D);
        vecs[5] = mk(72'h00, 1, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1, 32'h15);
        vecs[6] = mk(72'h01_02_03_04_80_00_00_13_57, 9, BUS_TO + 4, 32'h0, 1'b0,
                     1'b1, 32'h8000_0010, 1'b1, 32'h0102_0304, BUS_TO, 1, 32'h15);
        vecs[7] = mk(72'h00_00_00_00_FF_FF_FF_FF_57, 9, 1, 32'h0, 1'b1,
                     1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, 1, 1, 32'h06);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Partial frame abandoned after exactly RX_TO idle cycles, then a ping
        begin_frame(0, 32'h0, 1'b0);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        repeat (RX_TO) @(negedge clk);
        chk("rx_to_silent", 32'(got.size()), 32'd0);
        send_byte(8'h3F);
        finish_frame(1'b0, 32'h0, 1'b0, 32'h0, 0, 1, 32'hA5, 1'b1);

        // Gap of RX_TO-1 idle cycles keeps the frame alive
        begin_frame(4, 32'hA1B2_C3D4, 1'b0);
        send_byte(8'h52);
        repeat (RX_TO - 1) @(negedge clk);
        send_byte(8'h08);
        repeat (RX_TO - 1) @(negedge clk);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        finish_frame(1'b1, 32'h8, 1'b0, 32'h0, 4, 4, 32'hA1B2_C3D4, 1'b1);

        // Byte offered during RESP waits and is not lost
        begin_frame(0, 32'h0, 1'b0);
        send_byte(8'h3F);
        chk("rx_ready_in_resp", 32'(rx_ready), 32'd0);
        send_byte(8'h3F);
        finish_frame(1'b0, 32'h0, 1'b0, 32'h0, 0, 2, 32'hA5A5, 1'b0);

        // Reset during an outstanding bus request
        begin_frame(0, 32'h0, 1'b0);
        send_byte(8'h52); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (3) @(negedge clk);
        chk("req_before_rst", 32'(bus_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        run_vec(mk(72'h00_00_00_44_52, 5, 5, 32'h0BAD_F00D, 1'b1,
                   1'b1, 32'h44, 1'b0, 32'h0, 5, 4, 32'h0BAD_F00D));

        // Random frames against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [71:0] fr;
            logic [7:0]  cmd;
            int          r, n, ack_at;
            logic [31:0] rd;
            bit          txr, e_bus, e_we;
            logic [31:0] e_addr, e_wdata, e_resp;
            int          e_req, e_n;
            r = $urandom_range(0, 9);
            if (r < 4)      cmd = 8'h57;
            else if (r < 8) cmd = 8'h52;
            else if (r == 8) cmd = 8'h3F;
            else begin
                do cmd = 8'($urandom_range(0, 255));
                while (cmd == 8'h57 || cmd == 8'h52 || cmd == 8'h3F);
            end
            fr = {8'($urandom), $urandom, $urandom};
            fr[7:0] = cmd;
            n = (cmd == 8'h57) ? 9 : (cmd == 8'h52) ? 5 : 1;
            ack_at = $urandom_range(1, BUS_TO + 4);
            rd = $urandom;
            txr = 1'($urandom_range(0, 1));
            model(fr, ack_at, rd, e_bus, e_addr, e_we, e_wdata, e_req, e_n, e_resp);
            begin_frame(ack_at, rd, txr);
            for (int i = 0; i < n; i++) send_byte(fr[8*i +: 8]);
            finish_frame(e_bus, e_addr, e_we, e_wdata, e_req, e_n, e_resp, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
